// File: rtl/seq_detect_fsm_if.sv
// Serial-bit detector bus: input stream with qualifier, count clear, and the
// detector's match flags, count and debug state.
interface seq_detect_fsm_if #(
   parameter int CNT_W   = 8,
   parameter int STATE_W = 3
);
   logic               clear;
   logic               x_valid;
   logic               x;
   logic               y_mealy;
   logic               y_moore;
   logic [CNT_W-1:0]   match_count;
   logic [STATE_W-1:0] state_o;

   modport master (
      output clear, x_valid, x,
      input  y_mealy, y_moore, match_count, state_o
   );

   modport slave (
      input  clear, x_valid, x,
      output y_mealy, y_moore, match_count, state_o
   );
endinterface

// File: rtl/seq_detect_fsm.sv
// Programmable serial sequence detector (MSB-first pattern) with Mealy pulse,
// Moore flag and saturating match counter; transitions come from a KMP table.
module seq_detect_fsm #(
   parameter int          PAT_LEN = 4,
   parameter logic [15:0] PATTERN = 16'b1011,
   parameter bit          OVERLAP = 1'b1,
   parameter int          CNT_W   = 8,
   localparam int         SW      = $clog2(PAT_LEN + 1)
) (
   input  logic           clock,
   input  logic           reset,
   seq_detect_fsm_if.slave bus
);

   if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_len
      $fatal(1, "seq_detect_fsm: PAT_LEN must be in 2..16");
   end
   if ((PATTERN >> PAT_LEN) != 16'd0) begin : g_bad_pattern
      $fatal(1, "seq_detect_fsm: PATTERN has bits set above PAT_LEN");
   end

   typedef enum logic [SW-1:0] {
      S_IDLE = SW'(0),
      S_FULL = SW'(PAT_LEN)
   } state_t;

   // Pattern bit k in arrival order (k = 0 is received first).
   function automatic bit pat_bit(input int k);
      return PATTERN[PAT_LEN-1-k];
   endfunction

   // Longest proper border of the first len pattern bits.
   function automatic int border(input int len);
      int best;
      bit ok;
      best = 0;
      for (int j = 1; j < len; j++) begin
         ok = 1'b1;
         for (int i = 0; i < j; i++) begin
            if (pat_bit(i) != pat_bit(len - j + i)) ok = 1'b0;
         end
         if (ok) best = j;
      end
      return best;
   endfunction

   // KMP transition: follow the border chain until bit b extends a prefix.
   function automatic int advance(input int k, input bit b);
      int  cur;
      int  res;
      bit  done;
      cur  = k;
      res  = 0;
      done = 1'b0;
      for (int it = 0; it <= PAT_LEN + 1; it++) begin
         if (!done) begin
            if (cur < PAT_LEN && pat_bit(cur) == b) begin
               res  = cur + 1;
               done = 1'b1;
            end else if (cur == 0) begin
               res  = 0;
               done = 1'b1;
            end else begin
               cur = border(cur);
            end
         end
      end
      return res;
   endfunction

   logic [SW-1:0] nxt_zero [PAT_LEN+1];
   logic [SW-1:0] nxt_one  [PAT_LEN+1];

   // Without overlap a completed match restarts the search as if from S0.
   for (genvar gi = 0; gi <= PAT_LEN; gi++) begin : g_tbl
      localparam int FROM = (gi == PAT_LEN && !OVERLAP) ? 0 : gi;
      assign nxt_zero[gi] = SW'(advance(FROM, 1'b0));
      assign nxt_one[gi]  = SW'(advance(FROM, 1'b1));
   end

   state_t           state_reg;
   state_t           state_next;
   logic [CNT_W-1:0] count_reg;
   logic             match;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   always_ff @(posedge clock) begin
      if (reset) state_reg <= S_IDLE;
      else       state_reg <= state_next;
   end

   // Match is taken from the next state so self-overlapping patterns
   // (e.g. all-ones) still pulse when re-completing from S_FULL.
   always_comb begin
      state_next = state_reg;
      match      = 1'b0;
      if (bus.x_valid) begin
         state_next = state_t'(bus.x ? nxt_one[state_reg] : nxt_zero[state_reg]);
         match      = (state_next == S_FULL) && !reset;
      end
   end

   always_ff @(posedge clock) begin
      if (reset)                              count_reg <= '0;
      else if (bus.clear)                     count_reg <= '0;
      else if (match && count_reg != CNT_MAX) count_reg <= count_reg + CNT_W'(1);
   end

   assign bus.y_mealy     = match;
   assign bus.y_moore     = (state_reg == S_FULL);
   assign bus.match_count = count_reg;
   assign bus.state_o     = state_reg;

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Scoreboard bench for seq_detect_fsm: three instances (default, non-overlap,
// 2-bit counter) share one stimulus stream; each checked cycle targets one.
module tb_seq_detect_fsm;

   localparam int A  = 0;   // defaults
   localparam int B  = 1;   // OVERLAP = 0
   localparam int C  = 2;   // CNT_W = 2
   localparam int SK = -1;  // no check this cycle

   logic clk;
   logic rst_d, clr_d, val_d, x_d;

   seq_detect_fsm_if #(.CNT_W(8), .STATE_W(3)) ifa ();
   seq_detect_fsm_if #(.CNT_W(8), .STATE_W(3)) ifb ();
   seq_detect_fsm_if #(.CNT_W(2), .STATE_W(3)) ifc ();

   assign ifa.clear = clr_d;  assign ifa.x_valid = val_d;  assign ifa.x = x_d;
   assign ifb.clear = clr_d;  assign ifb.x_valid = val_d;  assign ifb.x = x_d;
   assign ifc.clear = clr_d;  assign ifc.x_valid = val_d;  assign ifc.x = x_d;

   seq_detect_fsm #(.PAT_LEN(4), .PATTERN(16'b1011), .OVERLAP(1'b1), .CNT_W(8)) dut_a (
      .clock(clk), .reset(rst_d), .bus(ifa.slave));
   seq_detect_fsm #(.PAT_LEN(4), .PATTERN(16'b1011), .OVERLAP(1'b0), .CNT_W(8)) dut_b (
      .clock(clk), .reset(rst_d), .bus(ifb.slave));
   seq_detect_fsm #(.PAT_LEN(4), .PATTERN(16'b1011), .OVERLAP(1'b1), .CNT_W(2)) dut_c (
      .clock(clk), .reset(rst_d), .bus(ifc.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string tag;
      int    d;
      int    em;
      int    emo;
      int    est;
      int    ecnt;
      int    n;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   fails  = 0;
   int   step_n = 0;

   task automatic chk(input string nm, input int n, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s step %0d: got %0h expected %0h", nm, n, act, expv);
      end
   endtask

   // Drive one cycle; expectations describe what is visible mid-cycle.
   task automatic step(input string tag, input bit r, input bit c, input bit v, input logic xb,
                       input int d, input int em, input int emo, input int est, input int ecnt);
      @(posedge clk);
      #1;
      rst_d = r;
      clr_d = c;
      val_d = v;
      x_d   = xb;
      step_n++;
      if (est >= 0) sb.push_back('{tag, d, em, emo, est, ecnt, step_n});
   endtask

   // Monitor: one popped expectation per checked cycle.
   exp_t        cur;
   logic        act_m, act_mo;
   logic [31:0] act_st, act_cnt;

   always @(negedge clk) begin
      if (sb.size() != 0) begin
         cur = sb.pop_front();
         case (cur.d)
            A: begin act_m = ifa.y_mealy; act_mo = ifa.y_moore;
                     act_st = 32'(ifa.state_o); act_cnt = 32'(ifa.match_count); end
            B: begin act_m = ifb.y_mealy; act_mo = ifb.y_moore;
                     act_st = 32'(ifb.state_o); act_cnt = 32'(ifb.match_count); end
            default: begin act_m = ifc.y_mealy; act_mo = ifc.y_moore;
                     act_st = 32'(ifc.state_o); act_cnt = 32'(ifc.match_count); end
         endcase
         $display("step %0d [%s] dut%0d mealy=%b moore=%b state=%0h count=%0h",
                  cur.n, cur.tag, cur.d, act_m, act_mo, act_st, act_cnt);
         chk({cur.tag, ".y_mealy"},     cur.n, 32'(act_m),  32'(cur.em));
         chk({cur.tag, ".y_moore"},     cur.n, 32'(act_mo), 32'(cur.emo));
         chk({cur.tag, ".state_o"},     cur.n, act_st,      32'(cur.est));
         chk({cur.tag, ".match_count"}, cur.n, act_cnt,     32'(cur.ecnt));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_d = 1'b1; clr_d = 1'b0; val_d = 1'b1; x_d = 1'b1;

      // Reset held two cycles with x=1 valid
      step("reset", 1, 0, 1, 1, A, SK, SK, SK, SK);
      step("reset", 1, 0, 1, 1, A, 0, 0, 0, 0);

      // Basic 1011
      step("basic", 0, 0, 1, 1, A, 0, 0, 0, 0);
      step("basic", 0, 0, 1, 0, A, 0, 0, 1, 0);
      step("basic", 0, 0, 1, 1, A, 0, 0, 2, 0);
      step("basic", 0, 0, 1, 1, A, 1, 0, 3, 0);
      step("basic", 0, 0, 0, 0, A, 0, 1, 4, 1);

      // Overlap 1011011, OVERLAP=1
      step("ovl1", 1, 0, 0, 0, A, SK, SK, SK, SK);
      step("ovl1", 0, 0, 1, 1, A, 0, 0, 0, 0);
      step("ovl1", 0, 0, 1, 0, A, 0, 0, 1, 0);
      step("ovl1", 0, 0, 1, 1, A, 0, 0, 2, 0);
      step("ovl1", 0, 0, 1, 1, A, 1, 0, 3, 0);
      step("ovl1", 0, 0, 1, 0, A, 0, 1, 4, 1);
      step("ovl1", 0, 0, 1, 1, A, 0, 0, 2, 1);
      step("ovl1", 0, 0, 1, 1, A, 1, 0, 3, 1);
      step("ovl1", 0, 0, 0, 0, A, 0, 1, 4, 2);

      // Same stream, OVERLAP=0
      step("ovl0", 1, 0, 0, 0, B, SK, SK, SK, SK);
      step("ovl0", 0, 0, 1, 1, B, 0, 0, 0, 0);
      step("ovl0", 0, 0, 1, 0, B, 0, 0, 1, 0);
      step("ovl0", 0, 0, 1, 1, B, 0, 0, 2, 0);
      step("ovl0", 0, 0, 1, 1, B, 1, 0, 3, 0);
      step("ovl0", 0, 0, 1, 0, B, 0, 1, 4, 1);
      step("ovl0", 0, 0, 1, 1, B, 0, 0, 0, 1);
      step("ovl0", 0, 0, 1, 1, B, 0, 0, 1, 1);
      step("ovl0", 0, 0, 0, 0, B, 0, 0, 1, 1);

      // Gaps with x unknown, plus an invalid completing bit at S3
      step("gap", 1, 0, 0, 0, A, SK, SK, SK, SK);
      step("gap", 0, 0, 1, 1, A, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step("gap", 0, 0, 0, 1'bx, A, 0, 0, 1, 0);
      step("gap", 0, 0, 1, 0, A, 0, 0, 1, 0);
      step("gap", 0, 0, 1, 1, A, 0, 0, 2, 0);
      step("gap", 0, 0, 0, 1, A, 0, 0, 3, 0);
      step("gap", 0, 0, 1, 1, A, 1, 0, 3, 0);
      for (int i = 0; i < 5; i++) step("gap", 0, 0, 0, 1'bx, A, 0, 1, 4, 1);

      // Saturation with a 2-bit counter: five back-to-back 1011
      step("sat", 1, 0, 0, 0, C, SK, SK, SK, SK);
      for (int p = 0; p < 5; p++) begin
         step("sat", 0, 0, 1, 1, C, SK, SK, SK, SK);
         step("sat", 0, 0, 1, 0, C, SK, SK, SK, SK);
         step("sat", 0, 0, 1, 1, C, SK, SK, SK, SK);
         step("sat", 0, 0, 1, 1, C, 1, 0, 3, (p < 3) ? p : 3);
      end
      step("sat", 0, 0, 0, 0, C, 0, 1, 4, 3);

      // Clear on a match edge: count cleared, state still advances
      step("clr", 0, 0, 1, 1, C, SK, SK, SK, SK);
      step("clr", 0, 0, 1, 0, C, SK, SK, SK, SK);
      step("clr", 0, 0, 1, 1, C, SK, SK, SK, SK);
      step("clr", 0, 1, 1, 1, C, 1, 0, 3, 3);
      step("clr", 0, 0, 0, 0, C, 0, 1, 4, 0);

      // Reset mid-pattern discards the prefix
      step("rstmid", 1, 0, 0, 0, A, SK, SK, SK, SK);
      step("rstmid", 0, 0, 1, 1, A, 0, 0, 0, 0);
      step("rstmid", 0, 0, 1, 0, A, 0, 0, 1, 0);
      step("rstmid", 0, 0, 1, 1, A, 0, 0, 2, 0);
      step("rstmid", 1, 0, 0, 0, A, SK, SK, SK, SK);
      step("rstmid", 0, 0, 1, 1, A, 0, 0, 0, 0);
      step("rstmid", 0, 0, 0, 0, A, 0, 0, 1, 0);

      // Fallback: 1001011 matches only on the last bit
      step("fallback", 1, 0, 0, 0, A, SK, SK, SK, SK);
      step("fallback", 0, 0, 1, 1, A, 0, 0, 0, 0);
      step("fallback", 0, 0, 1, 0, A, 0, 0, 1, 0);
      step("fallback", 0, 0, 1, 0, A, 0, 0, 2, 0);
      step("fallback", 0, 0, 1, 1, A, 0, 0, 0, 0);
      step("fallback", 0, 0, 1, 0, A, 0, 0, 1, 0);
      step("fallback", 0, 0, 1, 1, A, 0, 0, 2, 0);
      step("fallback", 0, 0, 1, 1, A, 1, 0, 3, 0);
      step("fallback", 0, 0, 0, 0, A, 0, 1, 4, 1);

      repeat (3) @(posedge clk);
      chk("scoreboard_drained", 0, 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
